// File: rtl/scr_arb_pkg.sv
// Shared types and constants for the scratch-RAM access arbiter.
// Source codes double as the SCR address-mux select values.
package scr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [SEL_W-1:0] SRC_REG  = 2'd0;
    localparam logic [SEL_W-1:0] SRC_IMM  = 2'd1;
    localparam logic [SEL_W-1:0] SRC_SPM1 = 2'd2;
    localparam logic [SEL_W-1:0] SRC_SP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping.
module rr_pick
    import scr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/scr_access_arbiter.sv
// Arbitrates the single-port scratch RAM among four requesters with round-robin
// selection, bounded lock bursts and a configurable read latency.
module scr_access_arbiter
    import scr_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_we,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   scr_addr_sel,
    output logic               scr_we,
    output logic [NUM_REQ-1:0] rd_valid,
    output logic               busy
);

    localparam int CNT_W   = 2;
    localparam int BURST_W = 4;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   win, win_nxt;
    logic               win_we, win_we_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_nxt;
    logic [CNT_W-1:0]   rd_cnt, rd_cnt_nxt;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               arb;
    logic               done;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win       <= '0;
            win_we    <= 1'b0;
            ptr       <= '0;
            burst_cnt <= '0;
            rd_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            win       <= win_nxt;
            win_we    <= win_we_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
            rd_cnt    <= rd_cnt_nxt;
        end
    end

    // Lock continuation only applies when an access is completing, never from IDLE.
    always_comb begin
        state_nxt  = state;
        win_nxt    = win;
        win_we_nxt = win_we;
        ptr_nxt    = ptr;
        burst_nxt  = burst_cnt;
        rd_cnt_nxt = rd_cnt;
        arb        = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: arb = 1'b1;
            ACCESS: begin
                if (win_we) begin
                    arb  = 1'b1;
                    done = 1'b1;
                end else begin
                    state_nxt  = RD_WAIT;
                    rd_cnt_nxt = CNT_W'(RD_LATENCY - 1);
                end
            end
            RD_WAIT: begin
                if (rd_cnt == '0) begin
                    arb  = 1'b1;
                    done = 1'b1;
                end else begin
                    rd_cnt_nxt = rd_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (arb) begin
            if (done && lock[win] && req[win] && burst_cnt < BURST_W'(MAX_BURST - 1)) begin
                state_nxt  = ACCESS;
                win_we_nxt = req_we[win];
                burst_nxt  = burst_cnt + BURST_W'(1);
            end else begin
                burst_nxt = '0;
                if (pick_any) begin
                    state_nxt  = ACCESS;
                    win_nxt    = pick_idx;
                    win_we_nxt = req_we[pick_idx];
                    ptr_nxt    = pick_idx + SEL_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_comb begin
        gnt          = (state == IDLE) ? '0 : onehot(win);
        scr_addr_sel = win;
        scr_we       = (state == ACCESS) && win_we;
        rd_valid     = (state == RD_WAIT && rd_cnt == '0) ? onehot(win) : '0;
        busy         = (state != IDLE);
    end

endmodule

// File: tb/tb_scr_access_arbiter.sv
// Directed scenarios plus random traffic, checked against an access-phase model
// of the arbiter (owner, phase within access, burst run length, rr pointer).
module tb_scr_access_arbiter;

    localparam int RD_LAT = 2;
    localparam int MB     = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req    = '0;
    logic [3:0] req_we = '0;
    logic [3:0] lock   = '0;
    logic [3:0] gnt;
    logic [1:0] scr_addr_sel;
    logic       scr_we;
    logic [3:0] rd_valid;
    logic       busy;

    int total = 0;
    int bad   = 0;

    bit m_active;
    bit m_we;
    int m_owner;
    int m_phase;
    int m_ptr;
    int m_run;

    scr_access_arbiter #(.RD_LATENCY(RD_LAT), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_we       (req_we),
        .lock         (lock),
        .gnt          (gnt),
        .scr_addr_sel (scr_addr_sel),
        .scr_we       (scr_we),
        .rd_valid     (rd_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 1'b0;
        m_we     = 1'b0;
        m_owner  = 0;
        m_phase  = 0;
        m_ptr    = 0;
        m_run    = 1;
    endtask

    // An access is one address phase, plus RD_LAT wait phases for a read.
    task automatic model_step();
        int pick;
        if (m_active && !(m_we ? (m_phase == 0) : (m_phase == RD_LAT))) begin
            m_phase++;
            return;
        end
        if (m_active && lock[m_owner] && req[m_owner] && m_run < MB) begin
            m_run++;
            m_we    = req_we[m_owner];
            m_phase = 0;
            return;
        end
        m_run = 1;
        pick  = -1;
        for (int k = 0; k < 4; k++)
            if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
        if (pick < 0) begin
            m_active = 1'b0;
        end else begin
            m_active = 1'b1;
            m_owner  = pick;
            m_we     = req_we[pick];
            m_phase  = 0;
            m_ptr    = (pick + 1) % 4;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] e_gnt, e_rv;
        e_gnt = m_active ? 4'(1 << m_owner) : 4'b0000;
        e_rv  = (m_active && !m_we && m_phase == RD_LAT) ? 4'(1 << m_owner) : 4'b0000;
        check({tag, "_gnt"}, gnt, e_gnt);
        check({tag, "_sel"}, {2'b00, scr_addr_sel}, 4'(m_owner));
        check({tag, "_we"}, {3'b000, scr_we}, {3'b000, m_active && m_we && m_phase == 0});
        check({tag, "_rdv"}, rd_valid, e_rv);
        check({tag, "_busy"}, {3'b000, busy}, {3'b000, m_active});
    endtask

    task automatic applyStimulus(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; req_we = '0; lock = '0;
        model_reset();
        @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] seq3 [6];
        logic [3:0] seq4 [4];
        logic [3:0] rv4  [4];
        bit saw1;
        seq3 = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100};
        seq4 = '{4'b1000, 4'b1000, 4'b1000, 4'b0010};
        rv4  = '{4'b0000, 4'b0000, 4'b1000, 4'b0000};

        #1;
        do_reset();
        check("reset_gnt_const", gnt, 4'b0000);

        // Single read from requester 0
        req = 4'b0001; req_we = 4'b0000;
        applyStimulus("t1a");
        check("t1_gnt_const", gnt, 4'b0001);
        req = '0;
        for (int i = 0; i < RD_LAT; i++) applyStimulus("t1b");
        check("t1_rdv_const", rd_valid, 4'b0001);
        applyStimulus("t1c");
        check("t1_idle_const", {3'b000, busy}, 4'b0000);

        // All-write contention
        do_reset();
        req = 4'b1111; req_we = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("t2");
            check("t2_gnt_const", gnt, 4'(1 << (i % 4)));
            check("t2_we_const", {3'b000, scr_we}, 4'b0001);
        end

        // Lock burst after steering ptr to 2
        do_reset();
        req = 4'b0010; req_we = 4'b0010;
        applyStimulus("t3pre");
        req = '0;
        applyStimulus("t3pre");
        req = 4'b0101; req_we = 4'b0101; lock = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            applyStimulus("t3");
            check("t3_gnt_const", gnt, seq3[i]);
        end
        req = '0; lock = '0;
        applyStimulus("t3post");

        // Read on 3 with a pending write on 1: no bubble after read completes
        req = 4'b1000; req_we = 4'b0000;
        applyStimulus("t4");
        check("t4_gnt_const", gnt, seq4[0]);
        req = 4'b1010; req_we = 4'b0010;
        for (int i = 1; i < 4; i++) begin
            applyStimulus("t4");
            check("t4_gnt_const", gnt, seq4[i]);
            check("t4_rdv_const", rd_valid, rv4[i]);
        end
        req = '0;
        applyStimulus("t4post");

        // Withdrawal of a one-cycle request during RD_WAIT
        saw1 = 1'b0;
        req = 4'b1000; req_we = 4'b0000;
        applyStimulus("t5"); saw1 |= gnt[1];
        applyStimulus("t5"); saw1 |= gnt[1];
        req = 4'b1010;
        applyStimulus("t5"); saw1 |= gnt[1];
        req = '0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t5"); saw1 |= gnt[1];
        end
        check("t5_never_gnt1", {3'b000, saw1}, 4'b0000);
        check("t5_idle_const", {3'b000, busy}, 4'b0000);

        // Async reset between edges during RD_WAIT
        req = 4'b0100; req_we = 4'b0000;
        applyStimulus("t6");
        req = '0;
        applyStimulus("t6");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_gnt", gnt, 4'b0000);
        check("t6_rst_rdv", rd_valid, 4'b0000);
        check("t6_rst_misc", {scr_addr_sel, scr_we, busy}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0010; req_we = 4'b0010;
        applyStimulus("t6b");
        check("t6_gnt_const", gnt, 4'b0010);
        req = '0;
        applyStimulus("t6c");

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req    = 4'($urandom);
            req_we = 4'($urandom);
            lock   = 4'($urandom);
            applyStimulus("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
